pipelined_control_unit: RTL and testbench

Successor to the single-cycle MIPS decoder. Decodes the ID-stage instruction into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. Adds load-use hazard detection, branch flush, external memory-stall freeze, memory access size/sign mode, and illegal-opcode flagging. Sits between the IF/ID register and the datapath pipeline registers.

---
 rtl/mips_ctrl_pkg.sv | 80 ++++++++
 rtl/ctrl_decoder.sv | 75 +++++++
 rtl/pipelined_control_unit.sv | 141 ++++++++++++++
 tb/tb_pipelined_control_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the MIPS control path.
// Holds opcode values, funct-compatible ALU codes, memory access size
// encodings and the per-stage control bundle structs. The bundle is nested
// so that each pipeline stage keeps only the fields that later stages use.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;
  localparam logic [5:0] ALU_LUI  = 6'b111111;

  typedef enum logic [1:0] {
    MSZ_BYTE = 2'b00,
    MSZ_HALF = 2'b01,
    MSZ_WORD = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic      mem_read;
    logic      mem_write;
    mem_size_e mem_size;
    logic      mem_unsigned;
    wb_ctrl_t  wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic [5:0] alu_ctrl;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    mem_ctrl_t  mem;
  } ex_ctrl_t;

  typedef struct packed {
    logic     reg_dst;   // 1 = destination is rd (R-type), 0 = rt
    ex_ctrl_t ex;
  } id_ctrl_t;

  // Loads and stores encode their access width in the low two opcode bits:
  // x00 byte, x01 half, x11 word.
  function automatic mem_size_e size_of_op(input logic [5:0] op);
    case (op[1:0])
      2'b00:   return MSZ_BYTE;
      2'b01:   return MSZ_HALF;
      default: return MSZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational MIPS opcode/funct decoder.
// Ports:
//   i_op      opcode field
//   i_funct   funct field (used as the ALU code for R-type)
//   o_ctrl    decoded control bundle (all zero for unknown opcodes)
//   o_illegal 1 when the opcode is not recognised
// Destination-zero suppression and valid gating are left to the caller so
// the single-cycle path can reuse this block unchanged.
module ctrl_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output id_ctrl_t   o_ctrl,
  output logic       o_illegal
);

  function automatic id_ctrl_t imm_op(input logic [5:0] alu);
    id_ctrl_t c;
    c = '0;
    c.ex.alu_ctrl         = alu;
    c.ex.alu_src          = 1'b1;
    c.ex.mem.wb.reg_write = 1'b1;
    return c;
  endfunction

  function automatic id_ctrl_t load_op(input logic [5:0] op);
    id_ctrl_t c;
    c = imm_op(ALU_ADD);
    c.ex.mem.mem_read      = 1'b1;
    c.ex.mem.mem_size      = size_of_op(op);
    c.ex.mem.mem_unsigned  = op[2];
    c.ex.mem.wb.mem_to_reg = 1'b1;
    return c;
  endfunction

  function automatic id_ctrl_t store_op(input logic [5:0] op);
    id_ctrl_t c;
    c = '0;
    c.ex.alu_ctrl      = ALU_ADD;
    c.ex.alu_src       = 1'b1;
    c.ex.mem.mem_write = 1'b1;
    c.ex.mem.mem_size  = size_of_op(op);
    return c;
  endfunction

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.reg_dst              = 1'b1;
        o_ctrl.ex.alu_ctrl          = i_funct;
        o_ctrl.ex.mem.wb.reg_write  = 1'b1;
      end
      OP_ADDI:  o_ctrl = imm_op(ALU_ADD);
      OP_ADDIU: o_ctrl = imm_op(ALU_ADDU);
      OP_SLTI:  o_ctrl = imm_op(ALU_SLT);
      OP_SLTIU: o_ctrl = imm_op(ALU_SLTU);
      OP_ANDI:  o_ctrl = imm_op(ALU_AND);
      OP_ORI:   o_ctrl = imm_op(ALU_OR);
      OP_XORI:  o_ctrl = imm_op(ALU_XOR);
      OP_LUI:   o_ctrl = imm_op(ALU_LUI);
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: o_ctrl = load_op(i_op);
      OP_SB, OP_SH, OP_SW: o_ctrl = store_op(i_op);
      OP_BEQ, OP_BNE: begin
        o_ctrl.ex.alu_ctrl  = ALU_SUB;
        o_ctrl.ex.branch    = 1'b1;
        o_ctrl.ex.branch_ne = i_op[0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: decodes the ID-stage instruction and carries its
// control bundle through the ID/EX, EX/MEM and MEM/WB control registers,
// with load-use stall, branch flush and memory-stall freeze.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid/op/funct/rs/rt/rd IF/ID instruction fields
//   ex_branch_taken            branch resolved taken in EX (flush)
//   mem_stall                  data memory busy (freeze whole pipeline)
//   stall_id, flush_if_id      combinational hazard controls for IF/ID
//   ex_*                       ID/EX control register outputs
//   mem_*                      EX/MEM control register outputs
//   wb_*                       MEM/WB control register outputs
//   illegal_op                 one-cycle pulse per accepted illegal opcode
module pipelined_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 6,
  parameter int REG_AW    = 5,
  parameter int HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [5:0]           id_op,
  input  logic [5:0]           id_funct,
  input  logic [REG_AW-1:0]    id_rs,
  input  logic [REG_AW-1:0]    id_rt,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic                 ex_branch_taken,
  input  logic                 mem_stall,
  output logic                 stall_id,
  output logic                 flush_if_id,
  output logic [ALUCTRL_W-1:0] ex_alu_control,
  output logic                 ex_alu_src,
  output logic                 ex_branch,
  output logic                 ex_branch_ne,
  output logic [REG_AW-1:0]    ex_wr_addr,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [1:0]           mem_size,
  output logic                 mem_unsigned,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic [REG_AW-1:0]    wb_wr_addr,
  output logic                 illegal_op
);

  id_ctrl_t          w_dec;
  logic              w_dec_illegal;
  logic [REG_AW-1:0] w_dest;
  logic              w_reads_rt;
  logic              w_load_use;
  ex_ctrl_t          w_id_ctrl;
  logic [REG_AW-1:0] w_id_addr;

  ex_ctrl_t          r_ex;
  logic [REG_AW-1:0] r_ex_addr;
  mem_ctrl_t         r_mem;
  logic [REG_AW-1:0] r_mem_addr;
  wb_ctrl_t          r_wb;
  logic [REG_AW-1:0] r_wb_addr;
  logic              r_illegal;

  ctrl_decoder u_dec (
    .i_op      (id_op),
    .i_funct   (id_funct),
    .o_ctrl    (w_dec),
    .o_illegal (w_dec_illegal)
  );

  assign w_dest     = w_dec.reg_dst ? id_rd : id_rt;
  // R-type, stores and branches are the only formats that read rt.
  assign w_reads_rt = w_dec.reg_dst | w_dec.ex.mem.mem_write | w_dec.ex.branch;

  // An empty IF/ID slot reads no registers, so it never causes a stall.
  assign w_load_use = (HAZARD_EN != 0) && id_valid && r_ex.mem.mem_read &&
                      (r_ex_addr != '0) &&
                      ((r_ex_addr == id_rs) || (w_reads_rt && (r_ex_addr == id_rt)));

  // Gate the decoded bundle with id_valid and drop writes to register 0.
  // The write address is zeroed whenever nothing is written so bubbles and
  // stores/branches carry a clean address down the pipe.
  always_comb begin
    w_id_ctrl = '0;
    w_id_addr = '0;
    if (id_valid) begin
      w_id_ctrl                  = w_dec.ex;
      w_id_ctrl.mem.wb.reg_write = w_dec.ex.mem.wb.reg_write && (w_dest != '0);
      if (w_id_ctrl.mem.wb.reg_write) w_id_addr = w_dest;
    end
  end

  // rst_n gating keeps these quiet while the pipeline is held in reset.
  assign stall_id    = rst_n && (mem_stall || (!ex_branch_taken && w_load_use));
  assign flush_if_id = rst_n && !mem_stall && ex_branch_taken;

  // ID/EX, EX/MEM, MEM/WB stage registers. mem_stall freezes all of them.
  // illegal_op is cleared while frozen or squashed so a held instruction
  // reports only once, on the edge it is actually accepted into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex       <= '0;
      r_ex_addr  <= '0;
      r_mem      <= '0;
      r_mem_addr <= '0;
      r_wb       <= '0;
      r_wb_addr  <= '0;
      r_illegal  <= 1'b0;
    end else if (mem_stall) begin
      r_illegal  <= 1'b0;
    end else begin
      r_wb       <= r_mem.wb;
      r_wb_addr  <= r_mem_addr;
      r_mem      <= r_ex.mem;
      r_mem_addr <= r_ex_addr;
      if (ex_branch_taken || w_load_use) begin
        r_ex      <= '0;
        r_ex_addr <= '0;
      end else begin
        r_ex      <= w_id_ctrl;
        r_ex_addr <= w_id_addr;
      end
      r_illegal  <= id_valid && w_dec_illegal && !ex_branch_taken && !w_load_use;
    end
  end

  assign ex_alu_control = ALUCTRL_W'(r_ex.alu_ctrl);
  assign ex_alu_src     = r_ex.alu_src;
  assign ex_branch      = r_ex.branch;
  assign ex_branch_ne   = r_ex.branch_ne;
  assign ex_wr_addr     = r_ex_addr;
  assign mem_write      = r_mem.mem_write;
  assign mem_read       = r_mem.mem_read;
  assign mem_size       = r_mem.mem_size;
  assign mem_unsigned   = r_mem.mem_unsigned;
  assign wb_reg_write   = r_wb.reg_write;
  assign wb_mem_to_reg  = r_wb.mem_to_reg;
  assign wb_wr_addr     = r_wb_addr;
  assign illegal_op     = r_illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: two instances (hazard detection on and
// off) share the same stimulus; each is compared every cycle against an
// instruction-level reference model, plus directed scenario checks.
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] id_op = '0, id_funct = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       ex_branch_taken = 1'b0, mem_stall = 1'b0;

  always #5 clk = ~clk;

  // outputs: h_ = HAZARD_EN 1, n_ = HAZARD_EN 0
  logic       h_stall, h_flush, h_src, h_br, h_bne, h_mw, h_mr, h_uns, h_rw, h_m2r, h_ill;
  logic [5:0] h_alu;
  logic [4:0] h_ewa, h_wwa;
  logic [1:0] h_sz;
  logic       n_stall, n_flush, n_src, n_br, n_bne, n_mw, n_mr, n_uns, n_rw, n_m2r, n_ill;
  logic [5:0] n_alu;
  logic [4:0] n_ewa, n_wwa;
  logic [1:0] n_sz;

  pipelined_control_unit #(.ALUCTRL_W(6), .REG_AW(5), .HAZARD_EN(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .mem_stall(mem_stall), .stall_id(h_stall), .flush_if_id(h_flush),
    .ex_alu_control(h_alu), .ex_alu_src(h_src), .ex_branch(h_br), .ex_branch_ne(h_bne),
    .ex_wr_addr(h_ewa), .mem_write(h_mw), .mem_read(h_mr), .mem_size(h_sz),
    .mem_unsigned(h_uns), .wb_reg_write(h_rw), .wb_mem_to_reg(h_m2r),
    .wb_wr_addr(h_wwa), .illegal_op(h_ill));

  pipelined_control_unit #(.ALUCTRL_W(6), .REG_AW(5), .HAZARD_EN(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .mem_stall(mem_stall), .stall_id(n_stall), .flush_if_id(n_flush),
    .ex_alu_control(n_alu), .ex_alu_src(n_src), .ex_branch(n_br), .ex_branch_ne(n_bne),
    .ex_wr_addr(n_ewa), .mem_write(n_mw), .mem_read(n_mr), .mem_size(n_sz),
    .mem_unsigned(n_uns), .wb_reg_write(n_rw), .wb_mem_to_reg(n_m2r),
    .wb_wr_addr(n_wwa), .illegal_op(n_ill));

  logic [28:0] obs [2];
  assign obs[0] = {h_alu, h_src, h_br, h_bne, h_ewa, h_mw, h_mr, h_sz, h_uns,
                   h_rw, h_m2r, h_wwa, h_ill, h_stall, h_flush};
  assign obs[1] = {n_alu, n_src, n_br, n_bne, n_ewa, n_mw, n_mr, n_sz, n_uns,
                   n_rw, n_m2r, n_wwa, n_ill, n_stall, n_flush};

  // One in-flight instruction as seen by the reference model.
  typedef struct packed {
    logic [5:0] alu;
    logic       src, branch, bne, mread, mwrite;
    logic [1:0] msize;
    logic       muns, rw, m2r;
    logic [4:0] wa;
  } rec_t;

  rec_t m_ex [2], m_mem [2], m_wb [2];
  logic m_ill [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the instruction set rules.
  function automatic void tdec(input logic [5:0] op, fn, input logic [4:0] rt, rd,
                               output rec_t r, output logic rrt, output logic bad);
    r = '0; rrt = 1'b0; bad = 1'b0;
    if (op == 6'h00) begin
      r.alu = fn; r.rw = 1'b1; r.wa = rd; rrt = 1'b1;
    end else if (op >= 6'h08 && op <= 6'h0e) begin
      case (op[2:0])
        3'd0: r.alu = 6'h20;  3'd1: r.alu = 6'h21;
        3'd2: r.alu = 6'h2a;  3'd3: r.alu = 6'h2b;
        3'd4: r.alu = 6'h24;  3'd5: r.alu = 6'h25;
        default: r.alu = 6'h26;
      endcase
      r.src = 1'b1; r.rw = 1'b1; r.wa = rt;
    end else if (op == 6'h0f) begin
      r.alu = 6'h3f; r.src = 1'b1; r.rw = 1'b1; r.wa = rt;
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27}) begin
      r.alu = 6'h20; r.src = 1'b1; r.mread = 1'b1; r.m2r = 1'b1; r.rw = 1'b1; r.wa = rt;
      r.msize = (op[1:0] == 2'b00) ? 2'd0 : (op[1:0] == 2'b01) ? 2'd1 : 2'd2;
      r.muns = op[2];
    end else if (op inside {6'h28, 6'h29, 6'h2b}) begin
      r.alu = 6'h20; r.src = 1'b1; r.mwrite = 1'b1; rrt = 1'b1;
      r.msize = (op[1:0] == 2'b00) ? 2'd0 : (op[1:0] == 2'b01) ? 2'd1 : 2'd2;
    end else if (op == 6'h04 || op == 6'h05) begin
      r.alu = 6'h22; r.branch = 1'b1; r.bne = op[0]; rrt = 1'b1;
    end else begin
      bad = 1'b1;
    end
    if (r.wa == 5'd0) r.rw = 1'b0;
    if (!r.rw) r.wa = 5'd0;
  endfunction

  // Load-use hazard of instance k against the instruction now in ID.
  function automatic logic m_hz(input int k, input logic rrt);
    return (k == 0) && id_valid && m_ex[k].mread && (m_ex[k].wa != 5'd0) &&
           ((m_ex[k].wa == id_rs) || (rrt && (m_ex[k].wa == id_rt)));
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_ill[k] = 1'b0;
    end
  endtask

  // Apply ID inputs, then compare every output at the falling edge.
  task automatic drive(input logic v, input logic [5:0] op, fn, input logic [4:0] rs, rt, rd,
                       input logic br, input logic ms);
    rec_t r; logic rrt, bad, st, fl;
    logic [28:0] exp;
    id_valid = v; id_op = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_branch_taken = br; mem_stall = ms;
    @(negedge clk);
    tdec(id_op, id_funct, id_rt, id_rd, r, rrt, bad);
    for (int k = 0; k < 2; k++) begin
      st = mem_stall || (!ex_branch_taken && m_hz(k, rrt));
      fl = !mem_stall && ex_branch_taken;
      exp = {m_ex[k].alu, m_ex[k].src, m_ex[k].branch, m_ex[k].bne, m_ex[k].wa,
             m_mem[k].mwrite, m_mem[k].mread, m_mem[k].msize, m_mem[k].muns,
             m_wb[k].rw, m_wb[k].m2r, m_wb[k].wa, m_ill[k], st, fl};
      chk(k == 0 ? "model_hz1" : "model_hz0", {3'b0, obs[k]}, {3'b0, exp});
    end
  endtask

  // Advance the model by one clock alongside the DUT.
  task automatic advance();
    rec_t r, nex [2], nmem [2], nwb [2];
    logic rrt, bad, hz;
    logic nill [2];
    tdec(id_op, id_funct, id_rt, id_rd, r, rrt, bad);
    for (int k = 0; k < 2; k++) begin
      hz = m_hz(k, rrt);
      if (mem_stall) begin
        nex[k] = m_ex[k]; nmem[k] = m_mem[k]; nwb[k] = m_wb[k]; nill[k] = 1'b0;
      end else begin
        nwb[k]  = m_mem[k];
        nmem[k] = m_ex[k];
        nex[k]  = (ex_branch_taken || hz || !id_valid) ? '0 : r;
        nill[k] = id_valid && bad && !ex_branch_taken && !hz;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = nex[k]; m_mem[k] = nmem[k]; m_wb[k] = nwb[k]; m_ill[k] = nill[k];
    end
  endtask

  task automatic nop();
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    advance();
  endtask

  logic [5:0] op_tbl [22];

  initial begin
    op_tbl = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
               6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h28, 6'h29, 6'h2b,
               6'h04, 6'h05, 6'h3f};
    mreset();

    // reset: everything low even with stall/flush inputs asserted
    mem_stall = 1'b1; ex_branch_taken = 1'b1; id_valid = 1'b1; id_op = 6'h23; id_rt = 5'd3;
    @(posedge clk); #1;
    chk("reset_h", {3'b0, obs[0]}, 32'd0);
    chk("reset_n", {3'b0, obs[1]}, 32'd0);
    mem_stall = 1'b0; ex_branch_taken = 1'b0; id_valid = 1'b0;
    rst_n = 1'b1;

    // R-type ADD rd=3 followed by SW
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); advance();
    chk("add_ex_alu", {26'b0, h_alu}, 32'h20);
    drive(1'b1, 6'h2b, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0); advance();
    nop();
    chk("sw_mem_write", {31'b0, h_mw}, 32'd1);
    chk("add_wb_rw", {31'b0, h_rw}, 32'd1);
    chk("add_wb_addr", {27'b0, h_wwa}, 32'd3);
    nop();
    chk("sw_wb_rw", {31'b0, h_rw}, 32'd0);

    // LW rt=5 then ADD rs=5: one-cycle stall only with hazard detection
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0); advance();
    drive(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd7, 1'b0, 1'b0);
    chk("lu_stall_h", {31'b0, h_stall}, 32'd1);
    chk("lu_stall_n", {31'b0, n_stall}, 32'd0);
    advance();
    chk("lu_bubble_h", {26'b0, h_alu}, 32'd0);
    chk("lu_pass_n", {26'b0, n_alu}, 32'h20);
    drive(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd7, 1'b0, 1'b0);
    chk("lu_release_h", {31'b0, h_stall}, 32'd0);
    advance();
    chk("lu_add_ex_h", {26'b0, h_alu}, 32'h20);
    nop(); nop(); nop();

    // BEQ in EX resolves taken: flush and squash the following ADD
    drive(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0); advance();
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    chk("br_flush", {31'b0, h_flush}, 32'd1);
    advance();
    chk("br_bubble_addr", {27'b0, h_ewa}, 32'd0);
    nop(); nop();
    chk("br_no_wb", {31'b0, h_rw}, 32'd0);

    // LHU frozen in MEM for three cycles
    drive(1'b1, 6'h25, 6'h00, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0); advance();
    nop();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      chk("ms_stall", {31'b0, h_stall}, 32'd1);
      advance();
      chk("ms_size", {30'b0, h_sz}, 32'd1);
      chk("ms_uns", {31'b0, h_uns}, 32'd1);
    end
    nop();
    chk("ms_wb_m2r", {31'b0, h_m2r}, 32'd1);
    chk("ms_wb_addr", {27'b0, h_wwa}, 32'd6);

    // illegal opcode pulse
    drive(1'b1, 6'h3f, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); advance();
    chk("ill_pulse", {31'b0, h_ill}, 32'd1);
    nop();
    chk("ill_clear", {31'b0, h_ill}, 32'd0);

    // ADDI to r0 never writes
    drive(1'b1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0); advance();
    nop(); nop();
    chk("r0_no_wb", {31'b0, h_rw}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 7) != 0), op_tbl[$urandom_range(0, 21)], 6'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      advance();
    end

    // asynchronous reset with a load in MEM
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0); advance();
    nop();
    chk("arst_pre_mr", {31'b0, h_mr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_h", {3'b0, obs[0]}, 32'd0);
    chk("arst_n", {3'b0, obs[1]}, 32'd0);
    mreset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, op_tbl[$urandom_range(0, 21)], 6'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'b0, 1'b0);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
